// File: rtl/his_acq_sequencer_if.sv
// Sequencer data-path bundle: TDC event input, histogram write port and
// peak-detector result. The master side is the sequencer.
interface his_acq_sequencer_if #(
    parameter int NP = 10,
    parameter int NB = 5
);
    logic          tdcValid;
    logic [NP-1:0] tdcData;
    logic          tdcReady;
    logic          wrEn;
    logic [NP-1:0] data;
    logic          hisNum;
    logic          acqFinish;
    logic          peakDone;
    logic [NB-1:0] peak;

    modport master (
        input  tdcValid, tdcData, peakDone, peak,
        output tdcReady, wrEn, data, hisNum, acqFinish
    );

    modport slave (
        output tdcValid, tdcData, peakDone, peak,
        input  tdcReady, wrEn, data, hisNum, acqFinish
    );
endinterface

// File: rtl/his_acq_sequencer.sv
// Two-pass histogram acquisition sequencer: a coarse pass, then a fine pass,
// each collecting SHOTS non-zero TDC codes and then waiting for the peak
// detector (bounded by TIMEOUT cycles).
module his_acq_sequencer #(
    parameter int NP      = 10,
    parameter int NB      = 5,
    parameter int SHOTS   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    input  logic                abort,
    his_acq_sequencer_if.master bus,
    output logic [NB-1:0]       peakCH,
    output logic [NB-1:0]       peakFH,
    output logic                busy,
    output logic                frameValid,
    output logic                timeoutErr
);

    typedef enum logic [2:0] {
        IDLE,
        ACQ_CH,
        WAIT_CH,
        ACQ_FH,
        WAIT_FH,
        DONE
    } state_t;

    localparam logic [15:0] SHOTS_C   = 16'(SHOTS);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_t        state_q;
    logic [15:0]   shot_cnt_q;
    logic [15:0]   wait_cnt_q;
    logic          wr_en_q;
    logic [NP-1:0] data_q;
    logic          his_num_q;
    logic          last_wr_q;
    logic          acq_finish_q;
    logic          timeout_err_q;
    logic [NB-1:0] peak_ch_q;
    logic [NB-1:0] peak_fh_q;

    logic          in_acq;
    logic          event_hit;
    logic [15:0]   shot_cnt_d;
    logic [15:0]   wait_cnt_d;
    logic          last_shot;
    logic          timeout_hit;

    // Event qualification and saturating counter increments
    always_comb begin
        in_acq      = (state_q == ACQ_CH) || (state_q == ACQ_FH);
        event_hit   = in_acq && bus.tdcValid && (bus.tdcData != '0);
        shot_cnt_d  = (shot_cnt_q == '1) ? shot_cnt_q : shot_cnt_q + 16'd1;
        wait_cnt_d  = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 16'd1;
        last_shot   = event_hit && (shot_cnt_d == SHOTS_C);
        timeout_hit = (wait_cnt_d == TIMEOUT_C);
    end

    // Sequencer FSM with registered outputs; abort overrides every state
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q       <= IDLE;
            shot_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            wr_en_q       <= 1'b0;
            data_q        <= '0;
            his_num_q     <= 1'b0;
            last_wr_q     <= 1'b0;
            acq_finish_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            peak_ch_q     <= '0;
            peak_fh_q     <= '0;
        end else begin
            wr_en_q      <= 1'b0;
            last_wr_q    <= 1'b0;
            // acqFinish trails the final write strobe by one cycle
            acq_finish_q <= last_wr_q;
            if (abort) begin
                state_q      <= IDLE;
                his_num_q    <= 1'b0;
                acq_finish_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q       <= ACQ_CH;
                            his_num_q     <= 1'b0;
                            shot_cnt_q    <= '0;
                            timeout_err_q <= 1'b0;
                        end
                    end
                    ACQ_CH, ACQ_FH: begin
                        if (event_hit) begin
                            wr_en_q    <= 1'b1;
                            data_q     <= bus.tdcData;
                            shot_cnt_q <= shot_cnt_d;
                            if (last_shot) begin
                                last_wr_q  <= 1'b1;
                                wait_cnt_q <= '0;
                                state_q    <= (state_q == ACQ_CH) ? WAIT_CH : WAIT_FH;
                            end
                        end
                    end
                    WAIT_CH: begin
                        wait_cnt_q <= wait_cnt_d;
                        if (bus.peakDone) begin
                            peak_ch_q  <= bus.peak;
                            state_q    <= ACQ_FH;
                            his_num_q  <= 1'b1;
                            shot_cnt_q <= '0;
                        end else if (timeout_hit) begin
                            timeout_err_q <= 1'b1;
                            state_q       <= IDLE;
                            his_num_q     <= 1'b0;
                        end
                    end
                    WAIT_FH: begin
                        wait_cnt_q <= wait_cnt_d;
                        if (bus.peakDone) begin
                            peak_fh_q <= bus.peak;
                            state_q   <= DONE;
                            his_num_q <= 1'b0;
                        end else if (timeout_hit) begin
                            timeout_err_q <= 1'b1;
                            state_q       <= IDLE;
                            his_num_q     <= 1'b0;
                        end
                    end
                    DONE: begin
                        state_q   <= IDLE;
                        his_num_q <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.tdcReady  = in_acq;
    assign bus.wrEn      = wr_en_q;
    assign bus.data      = data_q;
    assign bus.hisNum    = his_num_q;
    assign bus.acqFinish = acq_finish_q;
    assign peakCH        = peak_ch_q;
    assign peakFH        = peak_fh_q;
    assign busy          = (state_q != IDLE);
    assign frameValid    = (state_q == DONE);
    assign timeoutErr    = timeout_err_q;

endmodule

// File: tb/tb_his_acq_sequencer.sv
// Directed bench for his_acq_sequencer with SHOTS=3, TIMEOUT=4.
module tb_his_acq_sequencer;

    logic       clk = 1'b0;
    logic       res;
    logic       start;
    logic       abort;
    logic [4:0] peakCH;
    logic [4:0] peakFH;
    logic       busy;
    logic       frameValid;
    logic       timeoutErr;
    int         errors = 0;
    int         checks = 0;

    his_acq_sequencer_if #(.NP(10), .NB(5)) bus ();

    his_acq_sequencer #(
        .NP(10), .NB(5), .SHOTS(3), .TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .abort      (abort),
        .bus        (bus),
        .peakCH     (peakCH),
        .peakFH     (peakFH),
        .busy       (busy),
        .frameValid (frameValid),
        .timeoutErr (timeoutErr)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res = 1'b0; start = 1'b0; abort = 1'b0;
        bus.tdcValid = 1'b0; bus.tdcData = '0; bus.peakDone = 1'b0; bus.peak = '0;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0d want 0", busy); end
        checks++; if (bus.wrEn !== 1'b0) begin errors++; $display("FAIL rst_wrEn: got %0d want 0", bus.wrEn); end
        checks++; if (bus.data !== 10'd0) begin errors++; $display("FAIL rst_data: got %0d want 0", bus.data); end
        checks++; if (bus.tdcReady !== 1'b0) begin errors++; $display("FAIL rst_tdcReady: got %0d want 0", bus.tdcReady); end
        checks++; if (peakCH !== 5'd0 || peakFH !== 5'd0) begin errors++; $display("FAIL rst_peaks: got %0d/%0d want 0/0", peakCH, peakFH); end
        checks++; if (timeoutErr !== 1'b0) begin errors++; $display("FAIL rst_timeoutErr: got %0d want 0", timeoutErr); end
        step(); step();
        res = 1'b1;
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_idle: busy got %0d want 0", busy); end
    endtask

    task automatic test_nominal();
        logic [9:0] codes [6];
        logic [4:0] pk [2];
        codes = '{10'd108, 10'd511, 10'd90, 10'd300, 10'd500, 10'd50};
        pk    = '{5'd7, 5'd12};
        start = 1'b1; step(); start = 1'b0;
        checks++; if (busy !== 1'b1 || bus.tdcReady !== 1'b1 || bus.hisNum !== 1'b0) begin
            errors++; $display("FAIL nom_start: busy/ready/hisNum got %0d/%0d/%0d want 1/1/0", busy, bus.tdcReady, bus.hisNum); end
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                bus.tdcValid = 1'b1; bus.tdcData = codes[p*3+i];
                step();
                checks++; if (bus.wrEn !== 1'b1 || bus.data !== codes[p*3+i] || bus.acqFinish !== 1'b0) begin
                    errors++; $display("FAIL nom_wr p%0d e%0d: wrEn/data/acqFinish got %0d/%0d/%0d want 1/%0d/0",
                                       p, i, bus.wrEn, bus.data, bus.acqFinish, codes[p*3+i]); end
            end
            // Offered after the final shot: must be ignored
            bus.tdcData = 10'd77;
            step();
            bus.tdcValid = 1'b0;
            checks++; if (bus.wrEn !== 1'b0 || bus.acqFinish !== 1'b1 || bus.data !== codes[p*3+2]) begin
                errors++; $display("FAIL nom_finish p%0d: wrEn/acqFinish/data got %0d/%0d/%0d want 0/1/%0d",
                                   p, bus.wrEn, bus.acqFinish, bus.data, codes[p*3+2]); end
            step();
            checks++; if (bus.acqFinish !== 1'b0 || bus.tdcReady !== 1'b0) begin
                errors++; $display("FAIL nom_finish_pulse p%0d: acqFinish/ready got %0d/%0d want 0/0", p, bus.acqFinish, bus.tdcReady); end
            bus.peakDone = 1'b1; bus.peak = pk[p];
            step();
            bus.peakDone = 1'b0;
            if (p == 0) begin
                checks++; if (bus.hisNum !== 1'b1 || peakCH !== 5'd7 || bus.tdcReady !== 1'b1) begin
                    errors++; $display("FAIL nom_fine_entry: hisNum/peakCH/ready got %0d/%0d/%0d want 1/7/1", bus.hisNum, peakCH, bus.tdcReady); end
            end
        end
        checks++; if (frameValid !== 1'b1 || peakCH !== 5'd7 || peakFH !== 5'd12 || bus.hisNum !== 1'b0) begin
            errors++; $display("FAIL nom_done: frameValid/peakCH/peakFH/hisNum got %0d/%0d/%0d/%0d want 1/7/12/0",
                               frameValid, peakCH, peakFH, bus.hisNum); end
        step();
        checks++; if (frameValid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL nom_after_done: frameValid/busy got %0d/%0d want 0/0", frameValid, busy); end
    endtask

    task automatic test_zero_codes();
        logic [9:0] codes [3];
        logic       exp_wr [3];
        logic [9:0] exp_data [3];
        codes    = '{10'd0, 10'd0, 10'd200};
        exp_wr   = '{1'b0, 1'b0, 1'b1};
        exp_data = '{10'd50, 10'd50, 10'd200};
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.tdcValid = 1'b1; bus.tdcData = codes[i];
            step();
            checks++; if (bus.wrEn !== exp_wr[i] || bus.data !== exp_data[i]) begin
                errors++; $display("FAIL zero_code e%0d: wrEn/data got %0d/%0d want %0d/%0d", i, bus.wrEn, bus.data, exp_wr[i], exp_data[i]); end
        end
        bus.tdcData = 10'd5; step();
        checks++; if (bus.tdcReady !== 1'b1) begin errors++; $display("FAIL zero_shot2: ready got %0d want 1", bus.tdcReady); end
        bus.tdcData = 10'd6; step();
        bus.tdcValid = 1'b0;
        checks++; if (bus.tdcReady !== 1'b0) begin errors++; $display("FAIL zero_shot3: ready got %0d want 0", bus.tdcReady); end
        abort = 1'b1; step(); abort = 1'b0;
        checks++; if (busy !== 1'b0 || bus.acqFinish !== 1'b0) begin
            errors++; $display("FAIL zero_abort: busy/acqFinish got %0d/%0d want 0/0", busy, bus.acqFinish); end
    endtask

    task automatic test_timeout();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.tdcValid = 1'b1; bus.tdcData = 10'(11 + i); step();
        end
        bus.tdcValid = 1'b0;
        step(); step(); step();
        checks++; if (timeoutErr !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL to_wait4: timeoutErr/busy got %0d/%0d want 0/1", timeoutErr, busy); end
        step();
        checks++; if (timeoutErr !== 1'b1 || busy !== 1'b0 || peakCH !== 5'd7) begin
            errors++; $display("FAIL to_expire: timeoutErr/busy/peakCH got %0d/%0d/%0d want 1/0/7", timeoutErr, busy, peakCH); end
        start = 1'b1; step(); start = 1'b0;
        checks++; if (timeoutErr !== 1'b0) begin errors++; $display("FAIL to_clear: timeoutErr got %0d want 0", timeoutErr); end
        for (int i = 0; i < 3; i++) begin
            bus.tdcValid = 1'b1; bus.tdcData = 10'(20 + i); step();
        end
        bus.tdcValid = 1'b0;
        step(); step(); step();
        bus.peakDone = 1'b1; bus.peak = 5'd21;
        step();
        bus.peakDone = 1'b0;
        checks++; if (peakCH !== 5'd21 || timeoutErr !== 1'b0 || bus.hisNum !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL to_collision: peakCH/timeoutErr/hisNum/busy got %0d/%0d/%0d/%0d want 21/0/1/1",
                               peakCH, timeoutErr, bus.hisNum, busy); end
    endtask

    task automatic test_abort();
        bus.tdcValid = 1'b1; bus.tdcData = 10'd33; abort = 1'b1;
        step();
        abort = 1'b0; bus.tdcValid = 1'b0;
        checks++; if (busy !== 1'b0 || bus.wrEn !== 1'b0 || bus.hisNum !== 1'b0 || peakCH !== 5'd21 || bus.tdcReady !== 1'b0) begin
            errors++; $display("FAIL abort_fh: busy/wrEn/hisNum/peakCH/ready got %0d/%0d/%0d/%0d/%0d want 0/0/0/21/0",
                               busy, bus.wrEn, bus.hisNum, peakCH, bus.tdcReady); end
        start = 1'b1; step(); start = 1'b0;
        bus.tdcValid = 1'b1; bus.tdcData = 10'd44; step();
        bus.tdcValid = 1'b0;
        start = 1'b1; bus.peakDone = 1'b1; bus.peak = 5'd9;
        step();
        start = 1'b0; bus.peakDone = 1'b0;
        checks++; if (bus.hisNum !== 1'b0 || bus.tdcReady !== 1'b1 || peakCH !== 5'd21) begin
            errors++; $display("FAIL busy_start: hisNum/ready/peakCH got %0d/%0d/%0d want 0/1/21", bus.hisNum, bus.tdcReady, peakCH); end
        bus.tdcValid = 1'b1; bus.tdcData = 10'd45; step();
        checks++; if (bus.tdcReady !== 1'b1) begin errors++; $display("FAIL busy_shot2: ready got %0d want 1", bus.tdcReady); end
        bus.tdcData = 10'd46; step();
        bus.tdcValid = 1'b0;
        checks++; if (bus.tdcReady !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL busy_shot3: ready/busy got %0d/%0d want 0/1", bus.tdcReady, busy); end
        abort = 1'b1; step(); abort = 1'b0;
    endtask

    task automatic test_async_reset();
        start = 1'b1; step(); start = 1'b0;
        bus.tdcValid = 1'b1; bus.tdcData = 10'd55; step();
        bus.tdcValid = 1'b0;
        checks++; if (bus.wrEn !== 1'b1 || bus.data !== 10'd55) begin
            errors++; $display("FAIL ar_pre: wrEn/data got %0d/%0d want 1/55", bus.wrEn, bus.data); end
        #2 res = 1'b0;
        #1;
        checks++; if (bus.wrEn !== 1'b0 || bus.data !== 10'd0 || busy !== 1'b0 || bus.tdcReady !== 1'b0) begin
            errors++; $display("FAIL ar_outputs: wrEn/data/busy/ready got %0d/%0d/%0d/%0d want 0/0/0/0",
                               bus.wrEn, bus.data, busy, bus.tdcReady); end
        checks++; if (peakCH !== 5'd0 || peakFH !== 5'd0 || bus.hisNum !== 1'b0 || bus.acqFinish !== 1'b0 || frameValid !== 1'b0) begin
            errors++; $display("FAIL ar_regs: peakCH/peakFH/hisNum/acqFinish/frameValid got %0d/%0d/%0d/%0d/%0d want 0/0/0/0/0",
                               peakCH, peakFH, bus.hisNum, bus.acqFinish, frameValid); end
        step();
        res = 1'b1;
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_release: busy got %0d want 0", busy); end
        start = 1'b1; step(); start = 1'b0;
        checks++; if (busy !== 1'b1 || bus.tdcReady !== 1'b1) begin
            errors++; $display("FAIL ar_restart: busy/ready got %0d/%0d want 1/1", busy, bus.tdcReady); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_zero_codes();
        test_timeout();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
